mult_div_unit: RTL and testbench



---
 rtl/mult_div_unit_if.sv | 42 ++++
 rtl/mult_div_unit.sv | 178 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// ============================================================================
// mult_div_unit_if : operand, start, status and HI/LO bundle of mult_div_unit
// Rev 1.0
// ============================================================================
`default_nettype none

interface mult_div_unit_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic              StartMult;
  logic              StartDiv;
  logic [DATA_W-1:0] HI;
  logic [DATA_W-1:0] LO;
  logic              Busy;
  logic              Done;
  logic              DivZero;
`ifdef MULTDIV_UNSIGNED_EN
  logic              Unsigned;

  modport master (
    output A, B, StartMult, StartDiv, Unsigned,
    input  HI, LO, Busy, Done, DivZero
  );
  modport slave (
    input  A, B, StartMult, StartDiv, Unsigned,
    output HI, LO, Busy, Done, DivZero
  );
`else
  modport master (
    output A, B, StartMult, StartDiv,
    input  HI, LO, Busy, Done, DivZero
  );
  modport slave (
    input  A, B, StartMult, StartDiv,
    output HI, LO, Busy, Done, DivZero
  );
`endif
endinterface

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
// mult_div_unit : multi-cycle Booth multiply / restoring divide owning HI/LO.
// MULTDIV_UNSIGNED_EN adds the Unsigned input (multu/divu).  Rev 1.0
// ============================================================================
`default_nettype none

module mult_div_unit #(
  parameter int DATA_W = 32
) (
  input  logic            Clk,
  input  logic            Reset,
  mult_div_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MULT   = 3'd1,
    S_DIV    = 3'd2,
    S_FINISH = 3'd3,
    S_DZERO  = 3'd4
  } state_t;

  state_t state, state_nx;

  logic [CNT_W-1:0]  cnt;
  logic [DATA_W:0]   mcand;
  logic [DATA_W:0]   p_hi;
  logic [DATA_W-1:0] p_lo;
  logic              q_m1;
  logic              mcorr;
  logic [DATA_W-1:0] rem, quo, dvsr;
  logic              neg_q, neg_r;
  logic [DATA_W-1:0] hi, lo;
  logic              busy, done, div_zero;

  logic uns_in;
`ifdef MULTDIV_UNSIGNED_EN
  assign uns_in = bus.Unsigned;
`else
  assign uns_in = 1'b0;
`endif

  logic              last_iter;
  logic [DATA_W-1:0] a_abs, b_abs;
  assign last_iter = (cnt == LAST_ITER);
  assign a_abs = (bus.A[DATA_W-1] && !uns_in) ? -bus.A : bus.A;
  assign b_abs = (bus.B[DATA_W-1] && !uns_in) ? -bus.B : bus.B;

  // Booth step: add/sub one bit wider than P_hi, then shift right arithmetically
  logic [DATA_W+1:0] p_ext, m_ext, booth_sum;
  logic [DATA_W:0]   p_hi_nx;
  logic [DATA_W-1:0] p_lo_nx, mult_hi;
  assign p_ext = {p_hi[DATA_W], p_hi};
  assign m_ext = {mcand[DATA_W], mcand};

  always_comb begin
    booth_sum = p_ext;
    case ({p_lo[0], q_m1})
      2'b01:   booth_sum = p_ext + m_ext;
      2'b10:   booth_sum = p_ext - m_ext;
      default: booth_sum = p_ext;
    endcase
  end

  assign p_hi_nx = booth_sum[DATA_W+1:1];
  assign p_lo_nx = {booth_sum[0], p_lo[DATA_W-1:1]};
  // Multiplier was consumed as signed; an unsigned one with MSB set needs +A*2^DATA_W
  assign mult_hi = p_hi_nx[DATA_W-1:0] + (mcorr ? mcand[DATA_W-1:0] : '0);

  logic [DATA_W:0]   div_shift, div_trial;
  logic [DATA_W-1:0] rem_nx, quo_nx;
  assign div_shift = {rem, quo[DATA_W-1]};
  assign div_trial = div_shift - {1'b0, dvsr};
  assign rem_nx    = div_trial[DATA_W] ? div_shift[DATA_W-1:0] : div_trial[DATA_W-1:0];
  assign quo_nx    = {quo[DATA_W-2:0], ~div_trial[DATA_W]};

  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    div_zero = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.StartMult)     state_nx = S_MULT;
        else if (bus.StartDiv) state_nx = (bus.B == '0) ? S_DZERO : S_DIV;
      end
      S_MULT, S_DIV: begin
        busy = 1'b1;
        if (last_iter) state_nx = S_FINISH;
      end
      S_FINISH: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      S_DZERO: begin
        div_zero = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // HI/LO load on the last iteration edge so they are valid while Done is high
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt   <= '0;
      mcand <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
      q_m1  <= 1'b0;
      mcorr <= 1'b0;
      rem   <= '0;
      quo   <= '0;
      dvsr  <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (bus.StartMult) begin
            mcand <= {bus.A[DATA_W-1] & ~uns_in, bus.A};
            p_hi  <= '0;
            p_lo  <= bus.B;
            q_m1  <= 1'b0;
            mcorr <= uns_in & bus.B[DATA_W-1];
          end else if (bus.StartDiv && (bus.B != '0)) begin
            rem   <= '0;
            quo   <= a_abs;
            dvsr  <= b_abs;
            neg_q <= ~uns_in & (bus.A[DATA_W-1] ^ bus.B[DATA_W-1]);
            neg_r <= ~uns_in & bus.A[DATA_W-1];
          end
        end
        S_MULT: begin
          cnt  <= cnt + 1'b1;
          p_hi <= p_hi_nx;
          p_lo <= p_lo_nx;
          q_m1 <= p_lo[0];
          if (last_iter) begin
            hi <= mult_hi;
            lo <= p_lo_nx;
          end
        end
        S_DIV: begin
          cnt <= cnt + 1'b1;
          rem <= rem_nx;
          quo <= quo_nx;
          if (last_iter) begin
            hi <= neg_r ? -rem_nx : rem_nx;
            lo <= neg_q ? -quo_nx : quo_nx;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  assign bus.HI      = hi;
  assign bus.LO      = lo;
  assign bus.Busy    = busy;
  assign bus.Done    = done;
  assign bus.DivZero = div_zero;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ============================================================================
// tb_mult_div_unit : vector table + scoreboard bench for mult_div_unit
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mult_div_unit;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult_div_unit_if #(.DATA_W(W)) bus ();

  mult_div_unit #(.DATA_W(W)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  typedef struct {
    logic          dz;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
  } exp_t;

  typedef struct {
    logic          m;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: signed arithmetic in 64 bits (truncating /, dividend-signed %)
  function automatic exp_t model_op(input logic m, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic signed [63:0] sa, sbv, r;
    sa  = {{32{a[W-1]}}, a};
    sbv = {{32{b[W-1]}}, b};
    e.dz = 1'b0;
    e.hi = '0;
    e.lo = '0;
    if (m) begin
      r = sa * sbv;
      e.hi = r[63:32];
      e.lo = r[31:0];
    end else if (b == '0) begin
      e.dz = 1'b1;
    end else begin
      r = sa / sbv;
      e.lo = r[31:0];
      r = sa % sbv;
      e.hi = r[31:0];
    end
    return e;
  endfunction

  task automatic issue(input logic m, input logic d, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic push, input exp_t e);
    @(negedge clk);
    bus.A = a;
    bus.B = b;
    bus.StartMult = m;
    bus.StartDiv = d;
    if (push) sb.push_back(e);
    @(negedge clk);
    bus.StartMult = 1'b0;
    bus.StartDiv = 1'b0;
  endtask

  task automatic wait_result(input string name, input int exp_lat);
    exp_t e;
    int   lat;
    logic hit;
    hit = 1'b0;
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.Done || bus.DivZero) begin
        hit = 1'b1;
        lat = i;
        break;
      end
      @(negedge clk);
    end
    check({name, "_seen"}, hit, 1'b1);
    if (!hit || sb.size() == 0) return;
    e = sb.pop_front();
    check({name, "_latency"}, lat, exp_lat);
    if (e.dz) begin
      check({name, "_divzero"}, {bus.DivZero, bus.Done, bus.Busy}, 3'b100);
    end else begin
      check({name, "_done_busy"}, {bus.DivZero, bus.Done, bus.Busy}, 3'b011);
    end
    check({name, "_hilo"}, {bus.HI, bus.LO}, {e.hi, e.lo});
    @(negedge clk);
    check({name, "_after"}, {bus.DivZero, bus.Done, bus.Busy, bus.HI, bus.LO},
          {3'b000, e.hi, e.lo});
  endtask

  task automatic quiet(input string name, input int n);
    int pulses;
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.Done || bus.DivZero) pulses++;
    end
    check({name, "_no_pulse"}, pulses, 0);
  endtask

  vec_t vecs[10];
  exp_t e;
  exp_t none;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 32'd7,          32'hFFFFFFFD,  32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1] = '{1'b1, 32'h7FFFFFFF,   32'h7FFFFFFF,  32'h3FFFFFFF, 32'h00000001};
    vecs[2] = '{1'b0, 32'h80000000,   32'hFFFFFFFF,  32'h00000000, 32'h80000000};
    vecs[3] = '{1'b0, 32'hFFFFFFF9,   32'd2,         32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4] = '{1'b0, 32'd7,          32'hFFFFFFFE,  32'h00000001, 32'hFFFFFFFD};
    vecs[5] = '{1'b1, 32'h80000000,   32'h80000000,  32'h40000000, 32'h00000000};
    vecs[6] = '{1'b1, 32'd0,          32'h12345678,  32'h00000000, 32'h00000000};
    vecs[7] = '{1'b0, 32'd100,        32'd7,         32'h00000002, 32'h0000000E};
    vecs[8] = '{1'b0, 32'd5,          32'd9,         32'h00000005, 32'h00000000};
    vecs[9] = '{1'b1, 32'd714156689,  32'd1722007169, 32'h11111111, 32'h11111111};
    none = '{1'b0, '0, '0};

    bus.A = '0;
    bus.B = '0;
    bus.StartMult = 1'b0;
    bus.StartDiv = 1'b0;
`ifdef MULTDIV_UNSIGNED_EN
    bus.Unsigned = 1'b0;
`endif
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_state", {bus.HI, bus.LO, bus.Busy, bus.Done, bus.DivZero}, '0);
    rst = 1'b0;

    for (int k = 0; k < 10; k++) begin
      e = '{1'b0, vecs[k].hi, vecs[k].lo};
      issue(vecs[k].m, ~vecs[k].m, vecs[k].a, vecs[k].b, 1'b1, e);
      wait_result($sformatf("vec%0d", k), 32);
    end

    // HI/LO now hold 0x11111111; divide by zero must leave them alone
    issue(1'b0, 1'b1, 32'd5, 32'd0, 1'b1, '{1'b1, 32'h11111111, 32'h11111111});
    wait_result("divzero", 0);
    quiet("divzero", 40);

    for (int k = 0; k < 6; k++) begin
      logic [W-1:0] ra, rb;
      logic         rm;
      ra = $urandom;
      rb = (k == 5) ? 32'd3 : $urandom;
      rm = k[0];
      issue(rm, ~rm, ra, rb, 1'b1, model_op(rm, ra, rb));
      wait_result($sformatf("rand%0d", k), 32);
    end

    issue(1'b1, 1'b1, 32'd3, 32'd4, 1'b1, '{1'b0, 32'h0, 32'd12});
    wait_result("both_starts", 32);
    quiet("both_starts", 5);

    // Start pulse and operand change while busy must be ignored
    issue(1'b1, 1'b0, 32'hFFFFFFF0, 32'd9, 1'b1, model_op(1'b1, 32'hFFFFFFF0, 32'd9));
    repeat (4) @(negedge clk);
    bus.StartDiv = 1'b1;
    bus.A = 32'd1000;
    bus.B = 32'd3;
    @(negedge clk);
    bus.StartDiv = 1'b0;
    wait_result("div_while_busy", 27);
    quiet("div_while_busy", 40);

    issue(1'b1, 1'b0, 32'd1234567, 32'd7654321, 1'b0, none);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_state", {bus.HI, bus.LO, bus.Busy, bus.Done, bus.DivZero}, '0);
    quiet("abort", 40);

`ifdef MULTDIV_UNSIGNED_EN
    bus.Unsigned = 1'b1;
    issue(1'b1, 1'b0, 32'hFFFFFFFF, 32'd2, 1'b1, '{1'b0, 32'h00000001, 32'hFFFFFFFE});
    wait_result("multu", 32);
    issue(1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, '{1'b0, 32'hFFFFFFFE, 32'h00000001});
    wait_result("multu_max", 32);
    issue(1'b0, 1'b1, 32'hFFFFFFFF, 32'd2, 1'b1, '{1'b0, 32'h00000001, 32'h7FFFFFFF});
    wait_result("divu", 32);
    bus.Unsigned = 1'b0;
`endif

    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
